uart_rx_framer: RTL

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver with a one-entry holding register and idle-gap framing.
// Bytes are delivered over a valid/ready port; sof_o/eof_o mark frame boundaries.
module uart_rx_framer #(
    parameter int CLK_DIV   = 40,
    parameter int IDLE_BITS = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       sof_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       eof_o,
    output logic       err_frame_o,
    output logic       err_ovr_o,
    output logic [1:0] state_o
);

    // Handshake: a byte transfers on any rising clk_i edge where valid_o && ready_i;
    // data_o/sof_o are stable while valid_o=1 and ready_i=0.

    localparam int PW       = $clog2(CLK_DIV);
    localparam int IDLE_MAX = IDLE_BITS * CLK_DIV;
    localparam int IW       = $clog2(IDLE_MAX + 1);

    localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV / 2 - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDLE_TOP = IW'(IDLE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic            rx_d;
    logic [PW-1:0]   phase;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [IW-1:0]   idle_cnt;
    logic            in_frame;
    logic            byte_done;
    logic            byte_sof;
    logic [7:0]      byte_data;

    assign state_o = state;

    // rx_d is the previous rx_s, used only for start-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            phase       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            idle_cnt    <= '0;
            in_frame    <= 1'b0;
            byte_done   <= 1'b0;
            byte_sof    <= 1'b0;
            byte_data   <= '0;
            eof_o       <= 1'b0;
            err_frame_o <= 1'b0;
        end else begin
            byte_done   <= 1'b0;
            eof_o       <= 1'b0;
            err_frame_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        state    <= START;
                        phase    <= '0;
                        idle_cnt <= '0;
                    end else if (rx_s && idle_cnt != IDLE_TOP) begin
                        idle_cnt <= idle_cnt + IW'(1);
                        // Fires only on the step into IDLE_TOP; saturation keeps it single.
                        if (idle_cnt == IDLE_TOP - IW'(1) && in_frame) begin
                            eof_o    <= 1'b1;
                            in_frame <= 1'b0;
                        end
                    end
                end
                START: begin
                    if (phase == PH_HALF) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            phase   <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                DATA: begin
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                STOP: begin
                    if (phase == PH_LAST) begin
                        state <= IDLE;
                        phase <= '0;
                        if (rx_s) begin
                            byte_done <= 1'b1;
                            byte_data <= shift;
                            byte_sof  <= !in_frame;
                            in_frame  <= 1'b1;
                        end else begin
                            err_frame_o <= 1'b1;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A full, unaccepted holding register keeps its byte; the newcomer is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o    <= '0;
            sof_o     <= 1'b0;
            valid_o   <= 1'b0;
            err_ovr_o <= 1'b0;
        end else begin
            err_ovr_o <= 1'b0;
            if (byte_done) begin
                if (!valid_o || ready_i) begin
                    data_o  <= byte_data;
                    sof_o   <= byte_sof;
                    valid_o <= 1'b1;
                end else begin
                    err_ovr_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
